pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low: asserted when 0, sampled on rising edge of clk.
REQ-004 SHALL have port stall  input  1  decode not ready; hold the PC and the fetch outputs.
REQ-005 SHALL have port br_taken  input  1  taken-branch redirect request this cycle.
REQ-006 SHALL have port br_base  input  64  PC of the branching instruction.
REQ-007 SHALL have port br_offset  input  64  sign-extended byte offset, already scaled by 4.
REQ-008 SHALL have port halt_req  input  1  request to stop fetching.
REQ-009 SHALL have port imem_rdata  input  32  instruction word at imem_addr, combinational read.
REQ-010 SHALL have port imem_addr  output  64  current PC, driven combinationally from the PC register.
REQ-011 SHALL have port if_instr  output  32  registered instruction to decode.
REQ-012 SHALL have port if_pc  output  64  registered PC of if_instr.
REQ-013 SHALL have port if_valid  output  1  if_instr/if_pc hold a real instruction.
REQ-014 SHALL have port misalign  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.
REQ-015 SHALL have port fetch_count  output  32  fetched-instruction counter (see Configuration).
REQ-016 SHALL have port redirect_count  output  32  taken-redirect counter (see Configuration).

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT on halt_req; HALT is left only by reset.
REQ-018 SHALL in BOOT hold the PC and drive if_valid=0.
REQ-019 SHALL in RUN with stall=0 and no redirect register if_instr<=imem_rdata, if_pc<=PC, if_valid<=1, PC<=PC+4; fetch latency is one cycle from PC to if_instr.
REQ-020 SHALL in RUN with stall=1 and no redirect hold PC, if_instr, if_pc and if_valid unchanged.
REQ-021 SHALL on br_taken=1 in RUN set PC<=(br_base+br_offset) with bits [1:0] forced to 00, and set if_valid<=0 (one-bubble flush), regardless of stall.
REQ-022 SHALL pulse misalign for exactly one cycle, the cycle after a redirect whose unmasked target[1:0] != 00.
REQ-023 SHALL compute PC+4 and br_base+br_offset modulo 2^64: carry-out is discarded and the result wraps silently (PC 64'hFFFF_FFFF_FFFF_FFFC +4 -> 0).
REQ-024 SHALL give priority reset > halt_req > br_taken > stall when events are simultaneous.
REQ-025 SHALL on halt_req in RUN enter HALT with if_valid<=0 and PC held; in HALT, br_taken and stall are ignored.
REQ-026 SHALL ignore br_taken and halt_req in BOOT.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, set PC=RESET_PC, state=BOOT, if_instr=32'h0, if_pc=64'h0, if_valid=0, misalign=0, fetch_count=0, redirect_count=0.
REQ-028 SHALL abort any stall, redirect or halt in progress when reset occurs mid-operation; no state survives reset.

Configuration
REQ-029 SHALL, with macro FETCH_PERF_COUNT_EN defined, increment fetch_count on every REQ-019 fetch and redirect_count on every REQ-021 redirect; both counters wrap at 2^32.
REQ-030 SHALL, without FETCH_PERF_COUNT_EN, keep both counter ports present and tied to 32'h0, with no counter registers synthesized.

Verification
REQ-031 SHALL cover: reset with RESET_PC=0, stall=0 -> if_valid=0 for one cycle, then if_pc=0,4,8 on consecutive cycles with if_instr=mem[0],mem[1],mem[2].
REQ-032 SHALL cover: stall=1 for 3 cycles at PC=8 -> if_pc, if_instr, imem_addr constant; fetch resumes with if_pc=8.
REQ-033 SHALL cover: br_taken=1, br_base=16, br_offset=-8, with stall=1 the same cycle -> next cycle if_valid=0 and imem_addr=8; the following cycle if_pc=8.
REQ-034 SHALL cover: br_base=0x100, br_offset=0x6 -> imem_addr=0x104 and misalign pulses for one cycle.
REQ-035 SHALL cover: PC=64'hFFFF_FFFF_FFFF_FFFC with one fetch -> imem_addr=0; halt_req with br_taken the same cycle -> HALT entered, if_valid=0, PC frozen.
REQ-036 SHALL cover: with FETCH_PERF_COUNT_EN, 10 fetches and 2 redirects -> fetch_count=10, redirect_count=2; reset=0 mid-stream -> both counters=0 and if_valid=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction-fetch PC unit: BOOT/RUN/HALT sequencing, one-cycle fetch register, branch redirect.
// Optional perf counters under `FETCH_PERF_COUNT_EN` (counters read as zero when undefined).
module pc_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_base,
  input  logic [63:0] br_offset,
  input  logic        halt_req,
  input  logic [31:0] imem_rdata,
  output logic [63:0] imem_addr,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        if_valid,
  output logic        misalign,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state;
  logic [63:0] pc;
  logic [63:0] target;
  logic        do_redir;
  logic        do_fetch;

  // Both adders wrap modulo 2^64; carry-out is simply dropped.
  assign target    = br_base + br_offset;
  assign imem_addr = pc;

  // Priority inside RUN: halt_req > br_taken > stall.
  assign do_redir = (state == RUN) && !halt_req && br_taken;
  assign do_fetch = (state == RUN) && !halt_req && !br_taken && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_instr <= 32'h0;
      if_pc    <= 64'h0;
      if_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= do_redir && (target[1:0] != 2'b00);
      case (state)
        BOOT: begin
          state    <= RUN;
          if_valid <= 1'b0;
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALT;
            if_valid <= 1'b0;
          end else if (br_taken) begin
            pc       <= {target[63:2], 2'b00};
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 64'd4;
          end
        end
        default: ; // HALT: frozen until reset
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redir_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= 32'h0;
      redir_cnt <= 32'h0;
    end else begin
      if (do_fetch) fetch_cnt <= fetch_cnt + 32'd1;
      if (do_redir) redir_cnt <= redir_cnt + 32'd1;
    end
  end

  assign fetch_count    = fetch_cnt;
  assign redirect_count = redir_cnt;
`else
  assign fetch_count    = 32'h0;
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetches are queued as stimulus is driven and
// popped when the fetch register updates; counters are checked against bench-side tallies.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset, stall, br_taken, halt_req;
  logic [63:0] br_base, br_offset;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_valid, misalign;
  logic [31:0] fetch_count, redirect_count;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } fetch_t;
  fetch_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int nf = 0;   // fetches the bench expects the DUT to have counted
  int nr = 0;   // redirects likewise

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_base(br_base), .br_offset(br_offset), .halt_req(halt_req),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .misalign(misalign),
    .fetch_count(fetch_count), .redirect_count(redirect_count)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[33:2] ^ 32'hC0DE_5A00;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; if a fetch is expected, queue it and retire it after the edge.
  task automatic tick(input bit ef, input logic [63:0] epc);
    fetch_t e;
    if (ef) begin
      q.push_back('{pc: epc, instr: mem(epc)});
      nf++;
    end
    @(posedge clk); #1;
    if (ef) begin
      e = q.pop_front();
      chk("fetch_valid", 64'(if_valid), 64'd1);
      chk("fetch_pc",    if_pc,         e.pc);
      chk("fetch_instr", 64'(if_instr), 64'(e.instr));
    end
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; halt_req = 0; br_base = 0; br_offset = 0;
  endtask

  task automatic redirect(input logic [63:0] b, input logic [63:0] o, input bit st);
    br_taken = 1; br_base = b; br_offset = o; stall = st;
    nr++;
    tick(0, 0);
    idle();
  endtask

  task automatic chk_counts(input string tag);
`ifdef FETCH_PERF_COUNT_EN
    chk({tag, "_fcnt"}, 64'(fetch_count),    64'(nf));
    chk({tag, "_rcnt"}, 64'(redirect_count), 64'(nr));
`else
    chk({tag, "_fcnt"}, 64'(fetch_count),    64'd0);
    chk({tag, "_rcnt"}, 64'(redirect_count), 64'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 0;
    tick(0, 0);
    tick(0, 0);
    nf = 0; nr = 0; q.delete();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_pc",    if_pc,         64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_mis",   64'(misalign), 64'd0);
    chk("rst_addr",  imem_addr,     64'd0);
    chk_counts("rst");
    reset = 1;
  endtask

  initial begin
    reset = 0; idle();
    do_reset();

    // BOOT: one bubble, PC held
    tick(0, 0);
    chk("boot_valid", 64'(if_valid), 64'd0);
    chk("boot_addr",  imem_addr,     64'd0);

    tick(1, 64'd0); tick(1, 64'd4); tick(1, 64'd8);

    // redirect 16-8 with stall the same cycle: redirect wins
    redirect(64'd16, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    chk("br_valid", 64'(if_valid), 64'd0);
    chk("br_addr",  imem_addr,     64'd8);
    chk("br_mis",   64'(misalign), 64'd0);

    // three stalled cycles at PC=8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      chk("stl_addr",  imem_addr,     64'd8);
      chk("stl_pc",    if_pc,         64'd8);
      chk("stl_instr", 64'(if_instr), 64'(mem(64'd8)));
      chk("stl_valid", 64'(if_valid), 64'd0);
    end
    stall = 0;
    tick(1, 64'd8); tick(1, 64'd12);

    // misaligned target: masked to 0x104, misalign pulses once
    redirect(64'h100, 64'h6, 1'b0);
    chk("mis_addr",  imem_addr,     64'h104);
    chk("mis_pulse", 64'(misalign), 64'd1);
    chk("mis_valid", 64'(if_valid), 64'd0);
    tick(1, 64'h104);
    chk("mis_clear", 64'(misalign), 64'd0);

    // wrap at top of address space
    redirect(64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 1'b0);
    chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'd0);
    chk_counts("run");

    // halt and branch together: halt wins, then everything is ignored
    halt_req = 1; br_taken = 1; br_base = 64'h40; br_offset = 64'h0;
    tick(0, 0);
    chk("halt_valid", 64'(if_valid), 64'd0);
    chk("halt_addr",  imem_addr,     64'd0);
    halt_req = 0;
    for (int i = 0; i < 3; i++) begin
      br_taken = i[0]; stall = ~i[0];
      tick(0, 0);
      chk("hold_addr",  imem_addr,     64'd0);
      chk("hold_valid", 64'(if_valid), 64'd0);
    end
    idle();
    chk_counts("halt");

    // restart; branch/halt during BOOT must be ignored
    do_reset();
    br_taken = 1; halt_req = 1; br_base = 64'h200; br_offset = 64'h0;
    tick(0, 0);
    chk("bootign_addr",  imem_addr,     64'd0);
    chk("bootign_valid", 64'(if_valid), 64'd0);
    idle();

    for (int i = 0; i < 6; i++) tick(1, 64'(4 * i));
    redirect(64'h1000, 64'h20, 1'b0);
    for (int i = 0; i < 2; i++) tick(1, 64'h1020 + 64'(4 * i));
    redirect(64'h80, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1, 64'h80 + 64'(4 * i));
    chk_counts("perf");

    // reset mid-stream with stall and branch pending
    stall = 1; br_taken = 1; br_base = 64'h300;
    do_reset();
    idle();
    tick(0, 0);
    tick(1, 64'd0);

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
